// File: rtl/uart_fifo_ctrl_if.sv
// Host-side handshake bundle for uart_fifo_ctrl: TX FIFO write port and
// first-word-fall-through RX FIFO read port.
interface uart_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  // Host side: writes characters to send, reads received characters.
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  // Controller side.
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// UART with TX and RX FIFOs. Frame: start, DATA_WIDTH bits LSB first,
// optional even/odd parity, one or two stop bits. Config is latched per frame.
module uart_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIV_WIDTH-1:0]         cfg_div,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop2,
  uart_fifo_ctrl_if.slave              bus,
  output logic                         tx_out,
  input  logic                         rx_in,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  tx_level,
  output logic [$clog2(FIFO_DEPTH):0]  rx_level,
  output logic                         rx_parity_err,
  output logic                         rx_frame_err,
  output logic                         rx_overrun,
  input  logic                         clear_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Divisors below 4 leave too little room for the mid-bit sample.
  logic [DIV_WIDTH-1:0] w_div_eff;
  assign w_div_eff = (cfg_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : cfg_div;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_tx_wptr, r_tx_rptr;
  logic [LW-1:0]         r_tx_level;
  logic                  r_tx_en;
  logic                  w_tx_push, w_tx_pop;
  logic [DATA_WIDTH-1:0] w_tx_head;
  state_t                r_tx_state;

  assign bus.tx_ready = r_tx_en && (r_tx_level < LW'(FIFO_DEPTH));
  assign w_tx_push    = bus.tx_valid && bus.tx_ready;
  assign w_tx_pop     = (r_tx_state == S_IDLE) && (r_tx_level != '0);
  assign w_tx_head    = r_tx_mem[r_tx_rptr];
  assign tx_level     = r_tx_level;

  // TX storage write; contents need no reset, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (rst && w_tx_push) r_tx_mem[r_tx_wptr] <= bus.tx_data;
  end

  // TX pointers and level; tx_ready held low until the cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_level <= '0;
      r_tx_en    <= 1'b0;
    end else begin
      r_tx_en <= 1'b1;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_level <= r_tx_level + LW'(1);
        2'b01:   r_tx_level <= r_tx_level - LW'(1);
        default: r_tx_level <= r_tx_level;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  logic [DIV_WIDTH-1:0]  r_tx_cnt, r_tx_div;
  logic [1:0]            r_tx_par;
  logic                  r_tx_stop2, r_tx_pbit, r_tx_second;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [BW-1:0]         r_tx_bit;
  logic                  r_tx_out, r_tx_busy;
  logic                  w_tx_bit_end, w_tx_par_en;

  assign w_tx_bit_end = (r_tx_cnt == r_tx_div - DIV_WIDTH'(1));
  assign w_tx_par_en  = r_tx_par[0] ^ r_tx_par[1];
  assign tx_out       = r_tx_out;
  assign tx_busy      = r_tx_busy;

  // Transmit sequencer; tx_out/tx_busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state  <= S_IDLE;
      r_tx_cnt    <= '0;
      r_tx_div    <= DIV_WIDTH'(4);
      r_tx_par    <= 2'b00;
      r_tx_stop2  <= 1'b0;
      r_tx_pbit   <= 1'b0;
      r_tx_second <= 1'b0;
      r_tx_shift  <= '0;
      r_tx_bit    <= '0;
      r_tx_out    <= 1'b1;
      r_tx_busy   <= 1'b0;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx_out  <= 1'b1;
          r_tx_busy <= 1'b0;
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_pbit  <= (^w_tx_head) ^ (cfg_parity == 2'b10);
            r_tx_div   <= w_div_eff;
            r_tx_par   <= cfg_parity;
            r_tx_stop2 <= cfg_stop2;
            r_tx_cnt   <= '0;
            r_tx_out   <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_out   <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= '0;
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + DIV_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == BW'(DATA_WIDTH - 1)) begin
              if (w_tx_par_en) begin
                r_tx_out   <= r_tx_pbit;
                r_tx_state <= S_PARITY;
              end else begin
                r_tx_out    <= 1'b1;
                r_tx_second <= 1'b0;
                r_tx_state  <= S_STOP;
              end
            end else begin
              r_tx_bit   <= r_tx_bit + BW'(1);
              r_tx_out   <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + DIV_WIDTH'(1);
          end
        end
        S_PARITY: begin
          if (w_tx_bit_end) begin
            r_tx_cnt    <= '0;
            r_tx_out    <= 1'b1;
            r_tx_second <= 1'b0;
            r_tx_state  <= S_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + DIV_WIDTH'(1);
          end
        end
        S_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_stop2 && !r_tx_second) begin
              r_tx_second <= 1'b1;
            end else begin
              r_tx_busy  <= 1'b0;
              r_tx_state <= S_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + DIV_WIDTH'(1);
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX synchroniser ----------------
  logic r_rx_sync1, r_rx_sync2;
  logic w_rx_line;
  assign w_rx_line = r_rx_sync2;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= rx_in;
      r_rx_sync2 <= r_rx_sync1;
    end
  end

  // ---------------- RX FSM ----------------
  state_t                r_rx_state;
  logic [DIV_WIDTH-1:0]  r_rx_cnt, r_rx_div;
  logic [1:0]            r_rx_par;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [BW-1:0]         r_rx_bit;
  logic                  r_rx_done;
  logic                  w_rx_bit_end, w_rx_half_end, w_rx_par_en, w_rx_par_bad;
  logic                  w_rx_push;

  assign w_rx_bit_end  = (r_rx_cnt == r_rx_div - DIV_WIDTH'(1));
  assign w_rx_half_end = (r_rx_cnt == (r_rx_div >> 1) - DIV_WIDTH'(1));
  assign w_rx_par_en   = r_rx_par[0] ^ r_rx_par[1];
  assign w_rx_par_bad  = w_rx_line ^ (^r_rx_shift) ^ (r_rx_par == 2'b10);
  // The character is delivered at the first stop-bit sample regardless of errors.
  assign w_rx_push     = (r_rx_state == S_STOP) && !r_rx_done && w_rx_bit_end;

  // Receive sequencer: mid-start check, then one sample every div clocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= DIV_WIDTH'(4);
      r_rx_par   <= 2'b00;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          if (!w_rx_line) begin
            r_rx_cnt   <= '0;
            r_rx_div   <= w_div_eff;
            r_rx_par   <= cfg_parity;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (w_rx_half_end) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            // A line already back high at mid-start was only a glitch.
            r_rx_state <= w_rx_line ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + DIV_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx_line, r_rx_shift[DATA_WIDTH-1:1]};
            if (r_rx_bit == BW'(DATA_WIDTH - 1)) begin
              r_rx_done  <= 1'b0;
              r_rx_state <= w_rx_par_en ? S_PARITY : S_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + BW'(1);
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + DIV_WIDTH'(1);
          end
        end
        S_PARITY: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_done  <= 1'b0;
            r_rx_state <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + DIV_WIDTH'(1);
          end
        end
        S_STOP: begin
          // After the stop sample, wait for an idle line so a break is one frame.
          if (r_rx_done) begin
            if (w_rx_line) r_rx_state <= S_IDLE;
          end else if (w_rx_bit_end) begin
            r_rx_cnt  <= '0;
            r_rx_done <= 1'b1;
            if (w_rx_line) r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + DIV_WIDTH'(1);
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_rx_wptr, r_rx_rptr;
  logic [LW-1:0]         r_rx_level;
  logic                  w_rx_pop, w_rx_full, w_rx_write;

  assign bus.rx_valid = (r_rx_level != '0);
  assign bus.rx_data  = r_rx_mem[r_rx_rptr];
  assign w_rx_pop     = bus.rx_valid && bus.rx_ready;
  assign w_rx_full    = (r_rx_level == LW'(FIFO_DEPTH));
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_rx_write   = w_rx_push && (!w_rx_full || w_rx_pop);
  assign rx_level     = r_rx_level;

  // RX storage write.
  always_ff @(posedge clk) begin
    if (rst && w_rx_write) r_rx_mem[r_rx_wptr] <= r_rx_shift;
  end

  // RX pointers and level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_level <= '0;
    end else begin
      if (w_rx_write) r_rx_wptr <= r_rx_wptr + PW'(1);
      if (w_rx_pop)   r_rx_rptr <= r_rx_rptr + PW'(1);
      case ({w_rx_write, w_rx_pop})
        2'b10:   r_rx_level <= r_rx_level + LW'(1);
        2'b01:   r_rx_level <= r_rx_level - LW'(1);
        default: r_rx_level <= r_rx_level;
      endcase
    end
  end

  // Sticky error flags; clear_err wins over a set in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst || clear_err) begin
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if ((r_rx_state == S_PARITY) && w_rx_bit_end && w_rx_par_bad) rx_parity_err <= 1'b1;
      if (w_rx_push && !w_rx_line)                                 rx_frame_err  <= 1'b1;
      if (w_rx_push && w_rx_full && !w_rx_pop)                     rx_overrun    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: reset, TX framing, loopback, FIFO
// full/wrap, RX overrun, framing/parity errors, glitch rejection, mid-frame reset.
module tb_uart_fifo_ctrl;
  localparam int DW   = 8;
  localparam int DEPTH = 16;
  localparam int DIVW = 16;
  localparam int LW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [DIVW-1:0] cfg_div = 16'd4;
  logic [1:0]      cfg_parity = 2'b00;
  logic            cfg_stop2 = 1'b0;
  logic            tx_out, rx_in, tx_busy;
  logic [LW-1:0]   tx_level, rx_level;
  logic            rx_parity_err, rx_frame_err, rx_overrun;
  logic            clear_err = 1'b0;
  logic            loop_en = 1'b0;
  logic            rx_drv = 1'b1;
  int              errors = 0;
  int              checks = 0;

  uart_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  assign rx_in = loop_en ? tx_out : rx_drv;

  uart_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .bus(bus), .tx_out(tx_out), .rx_in(rx_in), .tx_busy(tx_busy),
    .tx_level(tx_level), .rx_level(rx_level), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_dut();
    rst = 1'b0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0; clear_err = 1'b0;
    loop_en = 1'b0; rx_drv = 1'b1; cfg_stop2 = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic push_tx(input logic [7:0] b);
    bus.tx_data = b; bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
  endtask

  // Drive one serial frame on rx_in, each bit held div clocks.
  task automatic send_rx(input logic [7:0] b, input int div, input bit par_en,
                         input bit par_val, input bit stop_val);
    rx_drv = 1'b0; tick(div);
    for (int i = 0; i < 8; i++) begin rx_drv = b[i]; tick(div); end
    if (par_en) begin rx_drv = par_val; tick(div); end
    rx_drv = stop_val; tick(div);
    rx_drv = 1'b1; tick(2 * div);
    $display("rx frame sent data=%h stop=%0d", b, stop_val);
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0; bus.tx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", bus.tx_ready); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
    checks++; if (tx_level !== 5'd0 || rx_level !== 5'd0) begin errors++; $display("FAIL reset_levels: got %0d/%0d want 0/0", tx_level, rx_level); end
    checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {rx_parity_err, rx_frame_err, rx_overrun}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.tx_ready); end
    $display("reset sequence checked");
  endtask

  task automatic test_tx_frame();
    logic [9:0] frame;
    int n, busy_cnt;
    reset_dut();
    cfg_div = 16'd4; cfg_parity = 2'b00;
    frame = {1'b1, 8'hA5, 1'b0};
    push_tx(8'hA5);
    n = 0;
    @(negedge clk);
    while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_start_timeout: busy=%b want 1", tx_busy); end
    busy_cnt = 0;
    for (int i = 0; i < 44; i++) begin
      if (i > 0) @(negedge clk);
      if (tx_busy === 1'b1) busy_cnt++;
      if (i < 40) begin
        checks++;
        if (tx_out !== frame[i/4]) begin errors++; $display("FAIL tx_bit%0d_clk%0d: got %b want %b", i/4, i%4, tx_out, frame[i/4]); end
      end
    end
    checks++; if (busy_cnt != 40) begin errors++; $display("FAIL tx_busy_len: got %0d want 40", busy_cnt); end
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL tx_idle_line: got %b want 1", tx_out); end
    $display("tx frame a5 checked");
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b [3];
    int n;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    reset_dut();
    loop_en = 1'b1; cfg_div = 16'd8; cfg_parity = 2'b10;
    for (int i = 0; i < 3; i++) push_tx(exp_b[i]);
    n = 0;
    while (rx_level != 5'd3 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (rx_level !== 5'd3) begin errors++; $display("FAIL loop_rx_level: got %0d want 3", rx_level); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== exp_b[i]) begin
        errors++; $display("FAIL loop_rx_data%0d: got valid=%b data=%h want 1/%h", i, bus.rx_valid, bus.rx_data, exp_b[i]);
      end
      $display("rx pop data=%h", bus.rx_data);
      pop_rx();
    end
    checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin errors++; $display("FAIL loop_flags: got %b want 000", {rx_parity_err, rx_frame_err, rx_overrun}); end
    checks++; if (rx_level !== 5'd0) begin errors++; $display("FAIL loop_rx_empty: got %0d want 0", rx_level); end
  endtask

  task automatic test_tx_fifo_full();
    int got, n;
    reset_dut();
    loop_en = 1'b1; cfg_div = 16'd4; cfg_parity = 2'b00;
    for (int i = 0; i < 17; i++) begin
      checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL full_ready_push%0d: got %b want 1", i, bus.tx_ready); end
      push_tx(8'h80 + 8'(i));
    end
    checks++; if (tx_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", tx_level); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", bus.tx_ready); end
    push_tx(8'hEE);
    checks++; if (tx_level !== 5'd16) begin errors++; $display("FAIL full_reject: got %0d want 16", tx_level); end
    got = 0; n = 0;
    while (got < 17 && n < 3000) begin
      @(negedge clk); n++;
      if (bus.rx_valid === 1'b1) begin
        checks++;
        if (bus.rx_data !== 8'h80 + 8'(got)) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", got, bus.rx_data, 8'h80 + 8'(got)); end
        $display("rx pop data=%h", bus.rx_data);
        got++;
        bus.rx_ready = 1'b1;
      end else begin
        bus.rx_ready = 1'b0;
      end
    end
    @(posedge clk); #1; bus.rx_ready = 1'b0;
    checks++; if (got != 17) begin errors++; $display("FAIL wrap_count: got %0d want 17", got); end
    tick(60);
    checks++; if (tx_level !== 5'd0 || rx_level !== 5'd0) begin errors++; $display("FAIL wrap_drained: got %0d/%0d want 0/0", tx_level, rx_level); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL wrap_no_overrun: got %b want 0", rx_overrun); end
  endtask

  task automatic test_rx_overrun();
    reset_dut();
    cfg_div = 16'd8; cfg_parity = 2'b00;
    for (int i = 0; i < 17; i++) send_rx(8'h40 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
    checks++; if (rx_level !== 5'd16) begin errors++; $display("FAIL ovr_level: got %0d want 16", rx_level); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", rx_overrun); end
    checks++; if ({rx_parity_err, rx_frame_err} !== 2'b00) begin errors++; $display("FAIL ovr_other_flags: got %b want 00", {rx_parity_err, rx_frame_err}); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.rx_data !== 8'h40 + 8'(i)) begin errors++; $display("FAIL ovr_data%0d: got %h want %h", i, bus.rx_data, 8'h40 + 8'(i)); end
      pop_rx();
    end
    checks++; if (rx_level !== 5'd0 || rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_after_pop: level=%0d ovr=%b want 0/1", rx_level, rx_overrun); end
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin errors++; $display("FAIL ovr_clear: got %b want 000", {rx_parity_err, rx_frame_err, rx_overrun}); end
  endtask

  task automatic test_frame_err_glitch();
    reset_dut();
    cfg_div = 16'd8; cfg_parity = 2'b00;
    send_rx(8'h5A, 8, 1'b0, 1'b0, 1'b0);
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", rx_frame_err); end
    checks++; if (rx_level !== 5'd1 || bus.rx_data !== 8'h5A) begin errors++; $display("FAIL ferr_push: level=%0d data=%h want 1/5a", rx_level, bus.rx_data); end
    checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL ferr_parity: got %b want 0", rx_parity_err); end
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    pop_rx();
    rx_drv = 1'b0; tick(2); rx_drv = 1'b1; tick(40);
    $display("rx glitch of 2 clocks sent");
    checks++; if (rx_level !== 5'd0) begin errors++; $display("FAIL glitch_push: got level %0d want 0", rx_level); end
    checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin errors++; $display("FAIL glitch_flags: got %b want 000", {rx_parity_err, rx_frame_err, rx_overrun}); end
    cfg_parity = 2'b01;
    send_rx(8'h5A, 8, 1'b1, 1'b1, 1'b1);
    checks++; if (rx_parity_err !== 1'b1 || rx_frame_err !== 1'b0) begin errors++; $display("FAIL perr_flag: got p=%b f=%b want 1/0", rx_parity_err, rx_frame_err); end
    checks++; if (rx_level !== 5'd1 || bus.rx_data !== 8'h5A) begin errors++; $display("FAIL perr_push: level=%0d data=%h want 1/5a", rx_level, bus.rx_data); end
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    pop_rx();
    send_rx(8'h5B, 8, 1'b1, 1'b1, 1'b1);
    checks++; if (rx_parity_err !== 1'b0 || bus.rx_data !== 8'h5B) begin errors++; $display("FAIL pgood: perr=%b data=%h want 0/5b", rx_parity_err, bus.rx_data); end
    pop_rx();
  endtask

  task automatic test_reset_midframe();
    int n;
    reset_dut();
    loop_en = 1'b1; cfg_div = 16'd4; cfg_parity = 2'b00;
    push_tx(8'h00); push_tx(8'h11); push_tx(8'h22);
    n = 0;
    @(negedge clk);
    while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    checks++; if (tx_out !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL mid_pre: out=%b busy=%b want 0/1", tx_out, tx_busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_line: out=%b busy=%b want 1/0", tx_out, tx_busy); end
    checks++; if (tx_level !== 5'd0 || rx_level !== 5'd0) begin errors++; $display("FAIL mid_rst_levels: got %0d/%0d want 0/0", tx_level, rx_level); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", bus.tx_ready); end
    rst = 1'b1;
    tick(100);
    checks++; if (tx_out !== 1'b1 || tx_busy !== 1'b0 || rx_level !== 5'd0) begin errors++; $display("FAIL mid_idle_after: out=%b busy=%b rxl=%0d want 1/0/0", tx_out, tx_busy, rx_level); end
    checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin errors++; $display("FAIL mid_flags: got %b want 000", {rx_parity_err, rx_frame_err, rx_overrun}); end
    $display("mid-frame reset checked");
  endtask

  initial begin
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_tx_fifo_full();
    test_rx_overrun();
    test_frame_err_glitch();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
